// File: rtl/julia_pass_sequencer.sv
// Julia frame sequencer: seeds the math loop, recirculates results NUM_PASSES-1 times, then drains to the framebuffer.
// Ack/Wrreq are zero-latency from state and FIFO flags; Fb write lands 1 cycle after its pop. JULIA_PROGRESSIVE_EN adds Fb writes in RECIRC.
module julia_pass_sequencer #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 480,
  parameter int NUM_PASSES = 64
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Start,
  input  logic [103:0] i_Px_Data,
  input  logic         i_Res_Fifo_Empty,
  output logic         o_Res_Fifo_Ack,
  output logic [103:0] o_Px_Data,
  output logic         o_Seed_Fifo_Wrreq,
  input  logic         i_Seed_Fifo_Full,
  output logic [18:0]  o_Fb_Addr,
  output logic [7:0]   o_Fb_Data,
  output logic         o_Fb_We,
  output logic         o_Busy,
  output logic [7:0]   o_Pass,
  output logic         o_Frame_Done
);

  typedef struct packed {
    logic [7:0]  px_val;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] iter;
  } px_word_t;

  typedef enum logic [2:0] {IDLE, SEED, RECIRC, DRAIN, DONE} state_t;

  localparam logic [18:0] LAST_PIX  = 19'(H_RES * V_RES - 1);
  localparam logic [7:0]  PASS_END  = 8'(NUM_PASSES);
  localparam px_word_t    SEED_WORD = '{8'hFF, 32'h0, 32'h0, 32'h0};

  state_t      state, state_nxt;
  logic [18:0] pix, pix_nxt;
  logic [7:0]  pass, pass_nxt;
  logic        last_pix;
  logic        push, pop, fb_wr;

  assign last_pix = (pix == LAST_PIX);

  always_comb begin
    state_nxt = state;
    pix_nxt   = pix;
    pass_nxt  = pass;
    push      = 1'b0;
    pop       = 1'b0;
    fb_wr     = 1'b0;
    o_Px_Data = i_Px_Data;
    unique case (state)
      IDLE: begin
        if (i_Start) begin
          state_nxt = SEED;
          pix_nxt   = '0;
          pass_nxt  = '0;
        end
      end
      SEED: begin
        o_Px_Data = SEED_WORD;
        push      = ~i_Seed_Fifo_Full;
        if (push) begin
          if (last_pix) begin
            state_nxt = RECIRC;
            pix_nxt   = '0;
            pass_nxt  = 8'd1;
          end else begin
            pix_nxt = pix + 19'd1;
          end
        end
      end
      RECIRC: begin
        // Both sides must be ready; an empty-and-full cycle is a pure stall.
        pop  = ~i_Res_Fifo_Empty & ~i_Seed_Fifo_Full;
        push = pop;
`ifdef JULIA_PROGRESSIVE_EN
        fb_wr = pop;
`endif
        if (pop) begin
          if (last_pix) begin
            pix_nxt  = '0;
            pass_nxt = pass + 8'd1;
            if (pass + 8'd1 == PASS_END) state_nxt = DRAIN;
          end else begin
            pix_nxt = pix + 19'd1;
          end
        end
      end
      DRAIN: begin
        pop   = ~i_Res_Fifo_Empty;
        fb_wr = pop;
        if (pop) begin
          if (last_pix) begin
            state_nxt = DONE;
            pix_nxt   = '0;
          end else begin
            pix_nxt = pix + 19'd1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO strobes must stay quiet for the whole reset cycle, not just after it.
  assign o_Res_Fifo_Ack    = pop  & i_Rst_n;
  assign o_Seed_Fifo_Wrreq = push & i_Rst_n;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      pix       <= '0;
      pass      <= '0;
      o_Fb_We   <= 1'b0;
      o_Fb_Addr <= '0;
      o_Fb_Data <= '0;
    end else begin
      state   <= state_nxt;
      pix     <= pix_nxt;
      pass    <= pass_nxt;
      o_Fb_We <= fb_wr;
      if (fb_wr) begin
        o_Fb_Addr <= pix;
        o_Fb_Data <= i_Px_Data[103:96];
      end
    end
  end

  assign o_Busy       = (state != IDLE);
  assign o_Frame_Done = (state == DONE);
  assign o_Pass       = pass;

endmodule
